// File: rtl/matrix_pkg.sv
// Shared types and index constants for the 2x2 matrix job streamer.
// Operand order A11..B22, result order C11..C22.
package matrix_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        KICK    = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int N_OPERANDS = 8;
    localparam int N_RESULTS  = 4;

    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/matrix_result_serializer.sv
// Holds the four captured results and streams them out C11..C22.
// drained pulses when the C22 beat is accepted.
module matrix_result_serializer
    import matrix_pkg::*;
#(
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [RW-1:0] c11,
    input  logic [RW-1:0] c12,
    input  logic [RW-1:0] c21,
    input  logic [RW-1:0] c22,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [RW-1:0] m_data,
    output logic          m_last,
    output logic          drained
);

    logic [RW-1:0] res [N_RESULTS];
    logic [1:0]    out_idx;
    logic          valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RESULTS; i++) begin
                res[i] <= '0;
            end
            out_idx <= '0;
            valid_q <= 1'b0;
        end else if (capture) begin
            res[IDX_C11] <= c11;
            res[IDX_C12] <= c12;
            res[IDX_C21] <= c21;
            res[IDX_C22] <= c22;
            out_idx      <= IDX_C11;
            valid_q      <= 1'b1;
        end else if (valid_q && m_ready) begin
            if (out_idx == IDX_C22) begin
                valid_q <= 1'b0;
            end
            out_idx <= out_idx + 2'd1;
        end
    end

    // Data is gated so the port reads zero whenever no beat is offered.
    assign m_valid = valid_q;
    assign m_data  = valid_q ? res[out_idx] : '0;
    assign m_last  = valid_q && (out_idx == IDX_C22);
    assign drained = valid_q && m_ready && (out_idx == IDX_C22);

endmodule

// File: rtl/matrix_job_streamer.sv
// Byte-stream front end for the 2x2 matrix core: collect, kick,
// wait for done (with timeout), then drain four results.
module matrix_job_streamer
    import matrix_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          mm_start,
    output logic [DW-1:0] mm_a11,
    output logic [DW-1:0] mm_a12,
    output logic [DW-1:0] mm_a21,
    output logic [DW-1:0] mm_a22,
    output logic [DW-1:0] mm_b11,
    output logic [DW-1:0] mm_b12,
    output logic [DW-1:0] mm_b21,
    output logic [DW-1:0] mm_b22,
    input  logic          mm_done,
    input  logic [RW-1:0] mm_c11,
    input  logic [RW-1:0] mm_c12,
    input  logic [RW-1:0] mm_c21,
    input  logic [RW-1:0] mm_c22,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [RW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          err_timeout
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    state_t        nxt;
    logic [2:0]    in_idx;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] op [N_OPERANDS];
    logic          err_q;
    logic          accept;
    logic          capture;
    logic          timeout_hit;
    logic          drained;

    // Ready is also masked by rst so the port reads zero while in reset.
    assign s_ready     = (state == COLLECT) && !rst;
    assign accept      = s_valid && s_ready;
    assign capture     = (state == WAIT) && mm_done;
    assign timeout_hit = (state == WAIT) && !mm_done
                         && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        unique case (state)
            COLLECT: if (accept && in_idx == IDX_B22) nxt = KICK;
            KICK:    nxt = WAIT;
            WAIT: begin
                if (capture)          nxt = DRAIN;
                else if (timeout_hit) nxt = COLLECT;
            end
            DRAIN:   if (drained) nxt = COLLECT;
            default: nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            in_idx  <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_OPERANDS; i++) begin
                op[i] <= '0;
            end
        end else begin
            state <= nxt;
            if (accept) begin
                op[in_idx] <= s_data;
                in_idx     <= in_idx + 3'd1;
            end
            if (state == KICK) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mm_start    = (state == KICK);
    assign busy        = (state != COLLECT);
    assign err_timeout = err_q;

    assign mm_a11 = op[IDX_A11];
    assign mm_a12 = op[IDX_A12];
    assign mm_a21 = op[IDX_A21];
    assign mm_a22 = op[IDX_A22];
    assign mm_b11 = op[IDX_B11];
    assign mm_b12 = op[IDX_B12];
    assign mm_b21 = op[IDX_B21];
    assign mm_b22 = op[IDX_B22];

    matrix_result_serializer #(
        .RW(RW)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .c11     (mm_c11),
        .c12     (mm_c12),
        .c21     (mm_c21),
        .c22     (mm_c22),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .drained (drained)
    );

endmodule

// File: tb/tb_matrix_job_streamer.sv
// Randomised bench for matrix_job_streamer with a behavioural core
// and a scoreboard of expected result beats.
module tb_matrix_job_streamer;

    localparam int TIMEOUT = 32;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        mm_start;
    logic [7:0]  mm_a11, mm_a12, mm_a21, mm_a22;
    logic [7:0]  mm_b11, mm_b12, mm_b21, mm_b22;
    logic        mm_done;
    logic        core_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] mm_c11 = '0, mm_c12 = '0, mm_c21 = '0, mm_c22 = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        err_timeout;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int starts = 0;
    int start_cyc = 0;
    int first_valid_cyc = 0;
    int core_delay = 5;
    int cd = 0;
    bit rdy_rand = 0;

    beat_t       q[$];
    logic [15:0] log_q[$];

    assign mm_done = core_done | spur_done;

    always #5 clk = ~clk;

    matrix_job_streamer #(
        .DW(8),
        .RW(16),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .mm_start    (mm_start),
        .mm_a11      (mm_a11),
        .mm_a12      (mm_a12),
        .mm_a21      (mm_a21),
        .mm_a22      (mm_a22),
        .mm_b11      (mm_b11),
        .mm_b12      (mm_b12),
        .mm_b21      (mm_b21),
        .mm_b22      (mm_b22),
        .mm_done     (mm_done),
        .mm_c11      (mm_c11),
        .mm_c12      (mm_c12),
        .mm_c21      (mm_c21),
        .mm_c22      (mm_c22),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [15:0] dot(input int x1, input int y1,
                                        input int x2, input int y2);
        return 16'(x1 * y1 + x2 * y2);
    endfunction

    function automatic logic [63:0] pack8(input int b0, input int b1,
                                          input int b2, input int b3,
                                          input int b4, input int b5,
                                          input int b6, input int b7);
        return {8'(b7), 8'(b6), 8'(b5), 8'(b4),
                8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    // Expected beats straight from C = A x B on the bytes sent.
    task automatic expect_job(input logic [63:0] b);
        int a11, a12, a21, a22, b11, b12, b21, b22;
        logic [15:0] c [4];
        beat_t e;
        a11 = int'(b[7:0]);   a12 = int'(b[15:8]);
        a21 = int'(b[23:16]); a22 = int'(b[31:24]);
        b11 = int'(b[39:32]); b12 = int'(b[47:40]);
        b21 = int'(b[55:48]); b22 = int'(b[63:56]);
        c[0] = dot(a11, b11, a12, b21);
        c[1] = dot(a11, b12, a12, b22);
        c[2] = dot(a21, b11, a22, b21);
        c[3] = dot(a21, b12, a22, b22);
        for (int k = 0; k < 4; k++) begin
            e.d = c[k];
            e.l = (k == 3);
            q.push_back(e);
        end
    endtask

    // Behavioural core: done pulse core_delay cycles after start.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_done = 1'b1;
                    mm_c11 = dot(int'(mm_a11), int'(mm_b11),
                                 int'(mm_a12), int'(mm_b21));
                    mm_c12 = dot(int'(mm_a11), int'(mm_b12),
                                 int'(mm_a12), int'(mm_b22));
                    mm_c21 = dot(int'(mm_a21), int'(mm_b11),
                                 int'(mm_a22), int'(mm_b21));
                    mm_c22 = dot(int'(mm_a21), int'(mm_b12),
                                 int'(mm_a22), int'(mm_b22));
                end
            end
            if (mm_start && core_delay > 0) cd = core_delay;
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    bit          prev_hold = 0;
    bit          prev_valid = 0;
    bit          prev_err = 0;
    bit          prev_start = 0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_hold = 0;
            prev_valid = 0;
            prev_err = 0;
            prev_start = 0;
        end else begin
            chk("s_ready_vs_busy", int'(s_ready), int'(!busy));
            if (mm_start) begin
                chk("start_pulse_width", int'(prev_start), 0);
                starts++;
                start_cyc = cyc;
            end
            if (m_valid) begin
                if (!prev_valid) first_valid_cyc = cyc;
                if (prev_hold) begin
                    chk("hold_data", int'(m_data), int'(hold_d));
                    chk("hold_last", int'(m_last), int'(hold_l));
                end
                if (q.size() == 0) begin
                    chk("unexpected_beat", int'(m_valid), 0);
                end else begin
                    chk("beat_data", int'(m_data), int'(q[0].d));
                    chk("beat_last", int'(m_last), int'(q[0].l));
                    if (m_ready) begin
                        log_q.push_back(m_data);
                        void'(q.pop_front());
                    end
                end
                prev_hold = !m_ready;
                hold_d = m_data;
                hold_l = m_last;
            end else begin
                if (prev_hold) chk("valid_dropped", int'(m_valid), 1);
                prev_hold = 0;
            end
            if (prev_err) chk("err_sticky", int'(err_timeout), 1);
            prev_valid = m_valid;
            prev_err = err_timeout;
            prev_start = mm_start;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_s_ready"}, int'(s_ready), 0);
        chk({tag, "_mm_start"}, int'(mm_start), 0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_m_last"}, int'(m_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_operands"},
            int'(|{mm_a11, mm_a12, mm_a21, mm_a22,
                   mm_b11, mm_b12, mm_b21, mm_b22}), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        check_zero_outputs(tag);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] b, input int n,
                              input bit rnd);
        int guard;
        bit acc;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            acc = 0;
            while (!acc && guard < 500) begin
                @(posedge clk);
                #1;
                s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data = b[8*i +: 8];
                @(negedge clk);
                acc = s_valid && s_ready;
                guard++;
            end
            if (!acc) chk("send_accept_bound", int'(acc), 1);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) chk("idle_bound", g, 0);
    endtask

    task automatic run_job(input logic [63:0] b, input bit rnd,
                           input int delay);
        core_delay = delay;
        if (delay > 0 && delay <= TIMEOUT) expect_job(b);
        send_bytes(b, 8, rnd);
        @(negedge clk);
        chk("start_latency", int'(mm_start), 1);
        wait_idle();
    endtask

    task automatic chk_log(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_beats"}, log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_q.size()) chk({tag, "_val"}, int'(log_q[k]), e[k]);
        end
        log_q.delete();
    endtask

    task automatic wait_m_valid();
        int g;
        g = 0;
        @(negedge clk);
        while (!m_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("m_valid_bound", int'(m_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time-out expected completion");
        $fatal(1);
    end

    initial begin
        int s0, n;
        logic [63:0] ones8;
        ones8 = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        do_reset("reset");

        s0 = starts;
        log_q.delete();
        run_job(ones8, 0, 5);
        chk("basic_starts", starts - s0, 1);
        chk("basic_done_to_valid", first_valid_cyc - start_cyc, 6);
        chk("basic_busy_after", int'(busy), 0);
        chk_log("basic", 19, 22, 43, 50);

        run_job(pack8(255, 255, 255, 255, 255, 255, 255, 255), 0, 3);
        chk_log("overflow", 64514, 64514, 64514, 64514);

        m_ready = 1'b0;
        core_delay = 4;
        expect_job(ones8);
        send_bytes(ones8, 8, 1);
        wait_m_valid();
        @(posedge clk); #1; m_ready = 1'b1;
        @(posedge clk); #1; m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_data", int'(m_data), 22);
            chk("bp_valid", int'(m_valid), 1);
            chk("bp_s_ready", int'(s_ready), 0);
        end
        @(posedge clk); #1; m_ready = 1'b1;
        wait_idle();
        chk_log("bp", 19, 22, 43, 50);

        run_job(ones8, 1, TIMEOUT);
        chk("done_wins_err", int'(err_timeout), 0);
        chk_log("done_wins", 19, 22, 43, 50);

        core_delay = 0;
        send_bytes(pack8(9, 9, 9, 9, 9, 9, 9, 9), 8, 0);
        @(negedge clk);
        chk("tmo_start", int'(mm_start), 1);
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TIMEOUT + 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_no_beats", log_q.size(), 0);
        run_job(pack8(2, 0, 0, 2, 3, 4, 5, 6), 0, 3);
        chk("tmo_err_kept", int'(err_timeout), 1);
        chk_log("after_tmo", 6, 8, 10, 12);

        core_delay = 5;
        send_bytes(ones8, 5, 0);
        do_reset("rst_collect");
        run_job(pack8(2, 0, 0, 2, 1, 1, 1, 1), 0, 5);
        chk_log("rst_collect", 2, 2, 2, 2);

        m_ready = 1'b0;
        core_delay = 4;
        expect_job(ones8);
        send_bytes(ones8, 8, 0);
        wait_m_valid();
        @(posedge clk); #1; m_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; m_ready = 1'b0;
        @(negedge clk);
        chk("drain_beat2", int'(m_data), 43);
        do_reset("rst_drain");
        log_q.delete();
        m_ready = 1'b1;
        run_job(pack8(2, 0, 0, 2, 1, 1, 1, 1), 0, 5);
        chk_log("rst_drain", 2, 2, 2, 2);

        @(posedge clk); #1; spur_done = 1'b1;
        @(posedge clk); #1; spur_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_m_valid", int'(m_valid), 0);
        chk("spur_busy", int'(busy), 0);
        run_job(ones8, 0, 2);
        chk_log("spur", 19, 22, 43, 50);

        rdy_rand = 1;
        for (int j = 0; j < 20; j++) begin
            run_job({$urandom(), $urandom()}, 1,
                    int'($urandom_range(1, TIMEOUT)));
        end
        rdy_rand = 0;
        @(posedge clk); #1; m_ready = 1'b1;
        chk("rand_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_job_streamer.md
Name: matrix_job_streamer

Overview:
Initiator and streaming front end for the team's 2x2 matrix-multiply core. It accepts 8 operand bytes on a valid/ready input stream and assembles matrices A and B. It then pulses start to the core, waits for done, captures the four 16-bit results, and emits them on a valid/ready output stream. It sits between the byte-oriented system bus and the core's parallel start/done port.

Parameters:
DW, 8, operand element width; must match core operand ports
RW, 16, result element width; must match core result ports
TIMEOUT, 32, maximum WAIT-state cycles for mm_done before the job is abandoned (>=8)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
s_valid  in  1  operand byte valid
s_ready  out  1  operand byte accepted when s_valid&&s_ready
s_data  in  DW  operand byte; order A11,A12,A21,A22,B11,B12,B21,B22
mm_start  out  1  one-cycle start pulse to core
mm_a11/mm_a12/mm_a21/mm_a22  out  DW each  A operands to core
mm_b11/mm_b12/mm_b21/mm_b22  out  DW each  B operands to core
mm_done  in  1  core completion pulse
mm_c11/mm_c12/mm_c21/mm_c22  in  RW each  core results; valid in mm_done cycle
m_valid  out  1  result word valid
m_ready  in  1  downstream accepts when m_valid&&m_ready
m_data  out  RW  result word; order C11,C12,C21,C22
m_last  out  1  high with C22 beat
busy  out  1  high in KICK/WAIT/DRAIN
err_timeout  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset (async): state=COLLECT, in_idx=0, out_idx=0, tmo_cnt=0. All outputs 0: s_ready, mm_start, mm_a*/mm_b*, m_valid, m_data, m_last, busy, err_timeout. Captured C registers=0.
- COLLECT: s_ready=1. Each accepted byte is written to the operand register selected by in_idx, then in_idx++. The accept at in_idx==7 sets in_idx=0 and next state=KICK.
- KICK: mm_start=1 for exactly 1 cycle; s_ready=0; tmo_cnt=0; next state=WAIT.
- WAIT: s_ready=0; mm_start=0; tmo_cnt++ each cycle.
  - mm_done=1: capture all mm_c* into result regs, out_idx=0, next state=DRAIN.
  - tmo_cnt==TIMEOUT-1 with no mm_done: err_timeout=1, next state=COLLECT, no output beats.
  - mm_done in the same cycle as the timeout condition: done wins, capture results, no error.
- DRAIN: m_valid=1, m_data=result[out_idx], m_last=(out_idx==3).
  - On m_valid&&m_ready: out_idx++. After beat 3, next state=COLLECT.
  - While m_valid&&!m_ready, m_data and m_last are held stable.
  - m_valid never drops until the beat is accepted.
- Operand ports mm_a*/mm_b* are registered. They change only on COLLECT accepts, so they are stable from mm_start through mm_done as the core contract requires.
- mm_done outside WAIT is ignored; results are not recaptured.
- Width rules: results pass through unmodified at RW bits. The block does no arithmetic on data.
- Latency: last operand accept -> mm_start next cycle. mm_done -> first m_valid next cycle.
- Throughput: no overlap; the next job's operands are accepted only after the C22 beat is accepted.
- busy = state in {KICK, WAIT, DRAIN}.
- Reset mid-operation (any state) aborts the job immediately. No partial beats appear after reset; the collect index restarts at A11.

Decomposition:
- Package matrix_pkg:
  - state enum {COLLECT, KICK, WAIT, DRAIN}, 2 bits
  - N_OPERANDS=8, N_RESULTS=4
  - operand index constants IDX_A11..IDX_B22 (0..7)
  - result index constants IDX_C11..IDX_C22 (0..3)
- Sub-module: matrix_result_serializer. It holds the 4xRW capture registers, out_idx and the m_valid/m_data/m_last logic. It is loaded by a capture strobe and reports a drained pulse back to the top FSM.
- Top module contains the FSM, operand registers, in_idx and timeout counter.

Test Plan:
- Basic job: bytes 1,2,3,4,5,6,7,8, with a behavioural core replying mm_done 5 cycles after mm_start, and m_ready=1 -> one mm_start pulse; m_data 19,22,43,50; m_last only on 50; busy low afterwards.
- Overflow passthrough: all operand bytes 255, core model truncating to 16 bits -> four beats of 0xFC02 (64514).
- Backpressure plus input stalls: toggle s_valid randomly during collect; hold m_ready=0 for 3 cycles on beat 1 -> m_data=22 held stable and m_valid high throughout; all 4 beats delivered in order; s_ready=0 during DRAIN.
- Timeout: core never asserts mm_done -> err_timeout rises TIMEOUT cycles after KICK; no m_valid. A following job with a responsive core completes normally and err_timeout stays 1.
- Reset mid-job: assert rst after 5 bytes, and separately during DRAIN beat 2 -> all outputs 0 immediately. The next 8 bytes 2,0,0,2,1,1,1,1 yield 2,2,2,2.
- Spurious done: pulse mm_done during COLLECT -> no capture, no m_valid. A subsequent normal job produces correct results.
